// File: rtl/vregfile_pkg.sv
// Shared types and helpers for the vector register file.
// byte_merge works at a fixed maximum width; callers zero-extend and truncate.
package vregfile_pkg;

    localparam int unsigned VLEN_DEFAULT     = 128;
    localparam int unsigned NUM_REGS_DEFAULT = 32;
    localparam int unsigned VLEN_MAX         = 1024;
    localparam int unsigned BE_MAX           = VLEN_MAX / 8;

    typedef logic [4:0] vreg_addr_t;

    function automatic logic [VLEN_MAX-1:0] byte_merge(
        input logic [VLEN_MAX-1:0] old_v,
        input logic [VLEN_MAX-1:0] new_v,
        input logic [BE_MAX-1:0]   be
    );
        logic [VLEN_MAX-1:0] r;
        r = old_v;
        for (int unsigned k = 0; k < BE_MAX; k++) begin
            if (be[k]) r[8*k +: 8] = new_v[8*k +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/vreg_scoreboard.sv
// Per-register busy bits: reserve at issue, clear on writeback, flush clears all.
module vreg_scoreboard
    import vregfile_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] vs1_addr_i,
    input  logic [ADDR_W-1:0] vs2_addr_i,
    input  logic [ADDR_W-1:0] vs3_addr_i,
    output logic              vs1_busy_o,
    output logic              vs2_busy_o,
    output logic              vs3_busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Reserve is applied after the clear so a newer issue keeps ownership.
    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (wr_en_i) busy_d[wr_addr_i] = 1'b0;
            if (rsv_en_i) busy_d[rsv_addr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    assign vs1_busy_o = busy_q[vs1_addr_i] & ~(wr_en_i && (wr_addr_i == vs1_addr_i));
    assign vs2_busy_o = busy_q[vs2_addr_i] & ~(wr_en_i && (wr_addr_i == vs2_addr_i));
    assign vs3_busy_o = busy_q[vs3_addr_i] & ~(wr_en_i && (wr_addr_i == vs3_addr_i));

endmodule

// File: rtl/vregfile.sv
// Vector register file: three read ports plus v0 mask, one byte-masked write
// port with same-cycle bypass, and a busy scoreboard for RAW stalls.
module vregfile
    import vregfile_pkg::*;
#(
    parameter int unsigned VLEN     = VLEN_DEFAULT,
    parameter int unsigned NUM_REGS = NUM_REGS_DEFAULT,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] vs1_addr_i,
    output logic [VLEN-1:0]   vs1_data_o,
    output logic              vs1_busy_o,
    input  logic [ADDR_W-1:0] vs2_addr_i,
    output logic [VLEN-1:0]   vs2_data_o,
    output logic              vs2_busy_o,
    input  logic [ADDR_W-1:0] vs3_addr_i,
    output logic [VLEN-1:0]   vs3_data_o,
    output logic              vs3_busy_o,
    output logic [VLEN-1:0]   v0_mask_o,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [VLEN-1:0]   wr_data_i,
    input  logic [VLEN/8-1:0] wr_be_i,
    input  logic              flush_i
);

    logic [VLEN-1:0] regs_q [NUM_REGS];
    logic [VLEN-1:0] regs_d [NUM_REGS];

    function automatic logic [VLEN-1:0] merge_v(
        input logic [VLEN-1:0]   old_v,
        input logic [VLEN-1:0]   new_v,
        input logic [VLEN/8-1:0] be
    );
        logic [VLEN_MAX-1:0] m;
        m = byte_merge(VLEN_MAX'(old_v), VLEN_MAX'(new_v), BE_MAX'(be));
        return m[VLEN-1:0];
    endfunction

    always_comb begin
        regs_d = regs_q;
        if (wr_en_i) regs_d[wr_addr_i] = merge_v(regs_q[wr_addr_i], wr_data_i, wr_be_i);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) regs_q <= '{default: '0};
        else        regs_q <= regs_d;
    end

    // Reading the next-state array gives the byte-merged write bypass for free.
    assign vs1_data_o = regs_d[vs1_addr_i];
    assign vs2_data_o = regs_d[vs2_addr_i];
    assign vs3_data_o = regs_d[vs3_addr_i];
    assign v0_mask_o  = regs_d[0];

    vreg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .rsv_en_i   (rsv_en_i),
        .rsv_addr_i (rsv_addr_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .flush_i    (flush_i),
        .vs1_addr_i (vs1_addr_i),
        .vs2_addr_i (vs2_addr_i),
        .vs3_addr_i (vs3_addr_i),
        .vs1_busy_o (vs1_busy_o),
        .vs2_busy_o (vs2_busy_o),
        .vs3_busy_o (vs3_busy_o)
    );

endmodule

// File: tb/tb_vregfile.sv
// Directed scoreboard bench for vregfile with default VLEN=128, NUM_REGS=32.
module tb_vregfile;

    localparam int unsigned VLEN = 128;
    localparam int unsigned AW   = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   vs1_addr, vs2_addr, vs3_addr, rsv_addr, wr_addr;
    logic [VLEN-1:0] vs1_data, vs2_data, vs3_data, v0_mask, wr_data;
    logic            vs1_busy, vs2_busy, vs3_busy;
    logic            rsv_en, wr_en, flush;
    logic [VLEN/8-1:0] wr_be;

    vregfile dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vs1_addr_i (vs1_addr),
        .vs1_data_o (vs1_data),
        .vs1_busy_o (vs1_busy),
        .vs2_addr_i (vs2_addr),
        .vs2_data_o (vs2_data),
        .vs2_busy_o (vs2_busy),
        .vs3_addr_i (vs3_addr),
        .vs3_data_o (vs3_data),
        .vs3_busy_o (vs3_busy),
        .v0_mask_o  (v0_mask),
        .rsv_en_i   (rsv_en),
        .rsv_addr_i (rsv_addr),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_be_i    (wr_be),
        .flush_i    (flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           tag;
        logic [VLEN-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic expect_v(input string tag, input logic [VLEN-1:0] v);
        exp_q.push_back('{tag: tag, val: v});
    endtask

    task automatic check_v(input logic [VLEN-1:0] obs);
        exp_t e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_underflow: observed %h required an expected entry", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rsv_en = 1'b0; rsv_addr = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        flush = 1'b0;
    endtask

    logic [VLEN-1:0] pat3, aa, fives, merged7, data9, data4, ones;

    initial begin
        for (int k = 0; k < VLEN/8; k++) pat3[8*k +: 8] = k[7:0];
        aa      = {(VLEN/8){8'hAA}};
        fives   = {(VLEN/8){8'h55}};
        ones    = '1;
        merged7 = {aa[VLEN-1:32], fives[31:0]};
        data9   = {4{32'hDEADBEEF}};
        data4   = {4{32'h12345678}};

        rst_n = 1'b0; idle();
        vs1_addr = '0; vs2_addr = '0; vs3_addr = '0;
        tick(); tick();

        // reset readback
        rst_n = 1'b1;
        vs1_addr = 5'd0; vs2_addr = 5'd5; vs3_addr = 5'd31;
        expect_v("rst_v0_data", '0);  expect_v("rst_v5_data", '0);
        expect_v("rst_v31_data", '0); expect_v("rst_v0_mask", '0);
        expect_v("rst_busy1", '0); expect_v("rst_busy2", '0); expect_v("rst_busy3", '0);
        #1;
        check_v(vs1_data); check_v(vs2_data); check_v(vs3_data); check_v(v0_mask);
        check_v(VLEN'(vs1_busy)); check_v(VLEN'(vs2_busy)); check_v(VLEN'(vs3_busy));

        // full write v3, then v0
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = pat3; wr_be = '1;
        tick(); idle();
        vs1_addr = 5'd3;
        expect_v("full_v3", pat3);
        #1; check_v(vs1_data);

        wr_en = 1'b1; wr_addr = 5'd0; wr_data = VLEN'(1); wr_be = '1;
        tick(); idle();
        vs1_addr = 5'd0;
        expect_v("full_v0_read", VLEN'(1)); expect_v("full_v0_mask", VLEN'(1));
        #1; check_v(vs1_data); check_v(v0_mask);

        // masked write v7 with bypass in the write cycle
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = aa; wr_be = '1;
        tick();
        wr_data = fives; wr_be = 16'h000F; vs2_addr = 5'd7;
        expect_v("mask_v7_bypass", merged7);
        #1; check_v(vs2_data);
        tick(); idle();
        vs1_addr = 5'd7;
        expect_v("mask_v7_stored", merged7);
        #1; check_v(vs1_data);

        // v0 mask bypass on a partial write
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = ones; wr_be = 16'h0001;
        expect_v("v0_mask_bypass", VLEN'(8'hFF));
        #1; check_v(v0_mask);
        tick(); idle();
        expect_v("v0_mask_stored", VLEN'(8'hFF));
        #1; check_v(v0_mask);

        // reserve v9, then complete it
        rsv_en = 1'b1; rsv_addr = 5'd9; vs1_addr = 5'd9;
        expect_v("rsv_v9_same_cycle", '0);
        #1; check_v(VLEN'(vs1_busy));
        tick(); idle();
        expect_v("rsv_v9_next", VLEN'(1));
        #1; check_v(VLEN'(vs1_busy));
        tick();
        expect_v("rsv_v9_held", VLEN'(1));
        #1; check_v(VLEN'(vs1_busy));

        wr_en = 1'b1; wr_addr = 5'd9; wr_data = data9; wr_be = '1;
        expect_v("wr_v9_busy", '0); expect_v("wr_v9_bypass", data9);
        #1; check_v(VLEN'(vs1_busy)); check_v(vs1_data);
        tick(); idle();
        expect_v("wr_v9_busy_after", '0); expect_v("wr_v9_data_after", data9);
        #1; check_v(VLEN'(vs1_busy)); check_v(vs1_data);

        // write to a register that is not busy
        wr_en = 1'b1; wr_addr = 5'd10; wr_data = ones; wr_be = '1;
        tick(); idle();
        vs3_addr = 5'd10;
        expect_v("nonbusy_v10_data", ones); expect_v("nonbusy_v10_busy", '0);
        #1; check_v(vs3_data); check_v(VLEN'(vs3_busy));

        // reserve and write v4 together while already busy
        rsv_en = 1'b1; rsv_addr = 5'd4;
        tick(); idle();
        vs2_addr = 5'd4;
        expect_v("v4_busy_before", VLEN'(1));
        #1; check_v(VLEN'(vs2_busy));
        rsv_en = 1'b1; rsv_addr = 5'd4;
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = data4; wr_be = '1;
        expect_v("v4_busy_in_cycle", '0); expect_v("v4_bypass", data4);
        #1; check_v(VLEN'(vs2_busy)); check_v(vs2_data);
        tick(); idle();
        expect_v("v4_busy_after", VLEN'(1)); expect_v("v4_data_after", data4);
        #1; check_v(VLEN'(vs2_busy)); check_v(vs2_data);

        // flush beats a same-cycle reserve
        rsv_en = 1'b1; rsv_addr = 5'd1; tick();
        rsv_addr = 5'd2; tick();
        rsv_addr = 5'd3; tick(); idle();
        vs1_addr = 5'd1; vs2_addr = 5'd2; vs3_addr = 5'd3;
        expect_v("pre_flush_b1", VLEN'(1)); expect_v("pre_flush_b2", VLEN'(1));
        expect_v("pre_flush_b3", VLEN'(1));
        #1; check_v(VLEN'(vs1_busy)); check_v(VLEN'(vs2_busy)); check_v(VLEN'(vs3_busy));
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd6;
        tick(); idle();
        vs1_addr = 5'd6;
        expect_v("flush_b6", '0); expect_v("flush_b2", '0); expect_v("flush_b3", '0);
        expect_v("flush_v3_data", pat3);
        #1; check_v(VLEN'(vs1_busy)); check_v(VLEN'(vs2_busy)); check_v(VLEN'(vs3_busy));
        check_v(vs3_data);
        vs1_addr = 5'd4;
        expect_v("flush_b4", '0);
        #1; check_v(VLEN'(vs1_busy));

        // reset beats a same-cycle write and reserve
        rst_n = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = ones; wr_be = '1;
        rsv_en = 1'b1; rsv_addr = 5'd5;
        tick();
        rst_n = 1'b1; idle();
        vs1_addr = 5'd3; vs2_addr = 5'd7; vs3_addr = 5'd5;
        expect_v("rstw_v3", '0); expect_v("rstw_v7", '0); expect_v("rstw_mask", '0);
        expect_v("rstw_b5", '0);
        #1; check_v(vs1_data); check_v(vs2_data); check_v(v0_mask); check_v(VLEN'(vs3_busy));

        if (exp_q.size() != 0) begin
            n_err++;
            $error("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vregfile.md
Name: vregfile

Overview:
- Vector register file for the vector datapath.
- Holds NUM_REGS registers of VLEN bits each.
- Provides three combinational read ports (vs1, vs2, vs3/vd-old) and a dedicated v0 mask output.
- Supports one byte-masked write port with same-cycle write-to-read bypass.
- A per-register busy scoreboard lets issue logic stall on read-after-write hazards without a separate hazard unit.

Parameters:
- VLEN, 128, bits per vector register; must be a multiple of 8 and at least 32.
- NUM_REGS, 32, number of architectural vector registers; must be a power of two.
- ADDR_W, $clog2(NUM_REGS), register address width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- vs1_addr_i  in  ADDR_W  read port 1 address
- vs1_data_o  out  VLEN  read port 1 data
- vs1_busy_o  out  1  vs1 register has a pending write
- vs2_addr_i  in  ADDR_W  read port 2 address
- vs2_data_o  out  VLEN  read port 2 data
- vs2_busy_o  out  1  vs2 register has a pending write
- vs3_addr_i  in  ADDR_W  read port 3 address (old vd, for FMA and undisturbed writes)
- vs3_data_o  out  VLEN  read port 3 data
- vs3_busy_o  out  1  vs3 register has a pending write
- v0_mask_o  out  VLEN  current contents of v0, bypassed
- rsv_en_i  in  1  reserve vd at issue; marks it busy
- rsv_addr_i  in  ADDR_W  register to reserve
- wr_en_i  in  1  writeback valid
- wr_addr_i  in  ADDR_W  writeback register
- wr_data_i  in  VLEN  writeback data
- wr_be_i  in  VLEN/8  byte enables; bit k covers bits [8k+7:8k]
- flush_i  in  1  clear all busy bits; data is untouched

Behaviour:
- Storage:
  - NUM_REGS x VLEN flops.
  - v0 is an ordinary writable register; unlike the scalar file there is no hardwired-zero register.
  - Reset (rst_n=0 at posedge) clears every register and every busy bit to 0.
  - Reset overrides all other inputs in that cycle.
- Write:
  - When wr_en_i=1, at posedge each byte k of reg[wr_addr_i] with wr_be_i[k]=1 takes wr_data_i byte k.
  - Bytes with wr_be_i[k]=0 are unchanged.
  - wr_be_i all-zero with wr_en_i=1 leaves data unchanged but still clears busy.
- Read (combinational, 0-cycle latency):
  - data_o = reg[addr].
  - Bypass: if wr_en_i=1 and wr_addr_i==addr, each byte with wr_be_i[k]=1 is taken from wr_data_i; other bytes come from storage.
  - The same bypass applies to v0_mask_o when wr_addr_i==0.
- Scoreboard, one busy bit per register, resolved at posedge in this priority order:
  1. reset: all bits to 0.
  2. flush_i=1: all bits to 0, including any reservation presented in the same cycle.
  3. rsv_en_i=1: busy[rsv_addr_i] set to 1. If wr_en_i targets the same register in the same cycle, reserve wins and the bit stays 1, because the newer instruction owns it.
  4. wr_en_i=1 to a register not being reserved: busy[wr_addr_i] cleared to 0.
- Busy output:
  - busy_o = busy[addr] and not (wr_en_i and wr_addr_i==addr).
  - The completing write is visible the same cycle via bypass, so the consumer need not stall.
  - busy_o does not reflect a same-cycle reserve; that register reads busy from the next cycle.
- Writeback to a non-busy register is legal: data is written and busy stays 0.
- A reserve of an already busy register is legal and idempotent; the scoreboard does not count outstanding writes.
- Out-of-range addresses cannot occur because NUM_REGS is a power of two.
- Outputs after reset: all data_o and v0_mask_o are 0, all busy_o are 0.

Decomposition:
- vregfile_pkg holds:
  - VLEN_DEFAULT, NUM_REGS_DEFAULT.
  - typedef vreg_addr_t (logic [4:0]).
  - function byte_merge(old, new, be), shared by the write path and all four bypass paths.
- One sub-module, vreg_scoreboard: busy-bit array, reserve/clear/flush priority, and the three busy-port lookups.
- vregfile instantiates vreg_scoreboard plus the storage and bypass muxes.

Test Plan:
- Reset and readback: hold rst_n=0 two cycles, then read v0, v5 and v31 -> all data 0, all busy 0, v0_mask_o 0.
- Full write: write v3 with 0x0F0E..00 (all ones in be) -> next cycle vs1_addr=3 returns 0x0F0E..00. Write v0 with 0x1 -> v0 reads back 0x1 and v0_mask_o=0x1.
- Masked write:
  - Preload v7=0xAAAA..AA.
  - Write 0x5555..55 with be=0x000F -> v7 reads back 0xAAAA..AA55555555 (low 4 bytes changed).
  - In the write cycle itself, vs2_addr=7 returns the same merged value via bypass.
- Scoreboard:
  - Reserve v9 -> vs1_busy=0 in the reserve cycle, then 1 on the following cycles.
  - Write v9 -> vs1_busy=0 in the write cycle with bypassed data, and stays 0 afterwards.
- Reserve and write to v4 in the same cycle (v4 previously busy) -> v4 busy remains 1 and data is updated.
- Flush and reset priority:
  - Reserve v1, v2 and v3, then assert flush_i together with rsv_en_i on v6 -> all busy 0 next cycle, data preserved.
  - Assert rst_n=0 together with wr_en_i -> register data 0 and write ignored.
